hazard_scoreboard: RTL and testbench

Parametrised scoreboard-based hazard unit for the five-stage MIPS pipeline (F D E M W), the successor to the fixed decode-compare hazard logic. It tracks every in-flight register write in a per-register entry, decides decode stalls from each operand's need-stage against the producer's result-ready stage, and emits forwarding selects pipelined to the stage where each operand is consumed. Register count and operand need-stages are generic, so new instruction classes need only a decode-side class code, not new compare terms.

---
 rtl/hazard_pkg.sv | 55 +++++
 rtl/hazard_sb_entry.sv | 37 +++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the scoreboard hazard unit: pipeline stage numbers,
// operand need-stage codes, result classes, forwarding selects and the per-register entry.
package hazard_pkg;

  localparam logic [2:0] STG_D = 3'd1;
  localparam logic [2:0] STG_E = 3'd2;
  localparam logic [2:0] STG_M = 3'd3;
  localparam logic [2:0] STG_W = 3'd4;

  // Need codes equal the consuming stage number so that distance = need - STG_D
  typedef enum logic [1:0] {
    NEED_NONE = 2'd0,
    NEED_D    = 2'd1,
    NEED_E    = 2'd2,
    NEED_M    = 2'd3
  } need_t;

  typedef enum logic {
    CLS_ALU  = 1'b0,
    CLS_LOAD = 1'b1
  } cls_t;

  localparam logic [2:0] SEL_RF = 3'd0;
  localparam logic [2:0] SEL_M  = 3'd3;
  localparam logic [2:0] SEL_W  = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [2:0] pos;
    logic [2:0] rdy;
  } entry_t;

  typedef struct packed {
    logic       haz;
    logic [2:0] sel;
  } opchk_t;

  // Where the producer will be when the operand is consumed, and whether that is too early
  function automatic opchk_t op_check(input entry_t e, input logic nz, input logic [1:0] need);
    opchk_t     r;
    logic [3:0] at;
    r.haz = 1'b0;
    r.sel = SEL_RF;
    at    = 4'(e.pos) + 4'(need) - 4'(STG_D);
    if (e.valid && nz && (need != NEED_NONE)) begin
      if (at <= 4'(e.rdy)) begin
        r.haz = 1'b1;
      end else if (at <= 4'(STG_W)) begin
        r.sel = 3'(at);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: tracks the youngest in-flight producer of a single register
// as it advances E -> M -> W and retires; a same-cycle issue overrides retirement.
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic       cls,
  output logic       valid,
  output logic [2:0] pos,
  output logic [2:0] rdy
);

  entry_t ent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent <= '0;
    end else if (issue) begin
      ent.valid <= 1'b1;
      ent.pos   <= STG_E;
      ent.rdy   <= (cls == CLS_LOAD) ? STG_M : STG_E;
    end else if (ent.valid) begin
      if (ent.pos == STG_W) begin
        ent.valid <= 1'b0;
      end else begin
        ent.pos <= ent.pos + 3'd1;
      end
    end
  end

  assign valid = ent.valid;
  assign pos   = ent.pos;
  assign rdy   = ent.rdy;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for the F/D/E/M/W pipeline: decode stall and forwarding selects.
// Define HAZARD_MDU_EN to let a busy or starting MDU stall a D-stage MDU instruction.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [1:0]    rs_need,
  input  logic [1:0]    rt_need,
  input  logic [AW-1:0] dst_d,
  input  logic          we_d,
  input  logic          cls_d,
  input  logic          flush_d,
  input  logic          mdu_d,
  input  logic          mdu_start,
  input  logic          mdu_busy,
  output logic          stall,
  output logic [2:0]    fwd_rs_d,
  output logic [2:0]    fwd_rt_d,
  output logic [2:0]    fwd_rs_e,
  output logic [2:0]    fwd_rt_e,
  output logic [2:0]    fwd_rt_m
);

  logic [NREG-1:0] ent_valid;
  logic [2:0]      ent_pos [NREG];
  logic [2:0]      ent_rdy [NREG];
  logic            issue_d;
  logic            mdu_stall;
  entry_t          rs_ent;
  entry_t          rt_ent;
  opchk_t          rs_chk;
  opchk_t          rt_chk;

  // Register 0 is hardwired, so its slot is permanently empty
  assign ent_valid[0] = 1'b0;
  assign ent_pos[0]   = '0;
  assign ent_rdy[0]   = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hazard_sb_entry u_ent (
      .clk   (clk),
      .reset (reset),
      .issue (issue_d && (dst_d == AW'(r))),
      .cls   (cls_d),
      .valid (ent_valid[r]),
      .pos   (ent_pos[r]),
      .rdy   (ent_rdy[r])
    );
  end

  // Source lookup against pre-issue state
  always_comb begin
    rs_ent = {ent_valid[rs_d], ent_pos[rs_d], ent_rdy[rs_d]};
    rt_ent = {ent_valid[rt_d], ent_pos[rt_d], ent_rdy[rt_d]};
    rs_chk = op_check(rs_ent, rs_d != '0, rs_need);
    rt_chk = op_check(rt_ent, rt_d != '0, rt_need);
  end

`ifdef HAZARD_MDU_EN
  assign mdu_stall = mdu_d & (mdu_start | mdu_busy);
`else
  logic unused_mdu;
  assign unused_mdu = mdu_d ^ mdu_start ^ mdu_busy;
  assign mdu_stall  = 1'b0;
`endif

  assign stall    = rs_chk.haz | rt_chk.haz | mdu_stall;
  assign fwd_rs_d = rs_chk.sel;
  assign fwd_rt_d = rt_chk.sel;
  assign issue_d  = we_d & (dst_d != '0) & ~stall & ~flush_d;

  // Select pipeline follows the instruction into E and M; a bubble carries SEL_RF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_rs_e <= SEL_RF;
      fwd_rt_e <= SEL_RF;
      fwd_rt_m <= SEL_RF;
    end else begin
      if (stall || flush_d) begin
        fwd_rs_e <= SEL_RF;
        fwd_rt_e <= SEL_RF;
      end else begin
        fwd_rs_e <= fwd_rs_d;
        fwd_rt_e <= fwd_rt_d;
      end
      fwd_rt_m <= fwd_rt_e;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed instruction sequences push expected outputs
// tagged by cycle; a negedge monitor pops and compares them against the DUT.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int I_STALL = 0;
  localparam int I_RSD   = 1;
  localparam int I_RTD   = 2;
  localparam int I_RSE   = 3;
  localparam int I_RTE   = 4;
  localparam int I_RTM   = 5;
`ifdef HAZARD_MDU_EN
  localparam logic [2:0] MDU_EXP = 3'd1;
`else
  localparam logic [2:0] MDU_EXP = 3'd0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] rs_need, rt_need;
  logic       we_d, cls_d, flush_d, mdu_d, mdu_start, mdu_busy;
  logic       stall;
  logic [2:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .rs_need   (rs_need),
    .rt_need   (rt_need),
    .dst_d     (dst_d),
    .we_d      (we_d),
    .cls_d     (cls_d),
    .flush_d   (flush_d),
    .mdu_d     (mdu_d),
    .mdu_start (mdu_start),
    .mdu_busy  (mdu_busy),
    .stall     (stall),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .fwd_rt_m  (fwd_rt_m)
  );

  always #5 clk = ~clk;

  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         q_cyc [$];
  int         q_id  [$];
  logic [2:0] q_val [$];
  string      q_tag [$];

  function automatic logic [2:0] dut_val(input int id);
    case (id)
      I_STALL: return {2'b00, stall};
      I_RSD:   return fwd_rs_d;
      I_RTD:   return fwd_rt_d;
      I_RSE:   return fwd_rs_e;
      I_RTE:   return fwd_rt_e;
      default: return fwd_rt_m;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] == cyc) begin
        n_cmp++;
        if (dut_val(q_id[i]) !== q_val[i]) begin
          n_fail++;
          $display("FAIL %s cycle %0d: got %0d, expected %0d", q_tag[i], cyc, dut_val(q_id[i]), q_val[i]);
        end
        q_cyc.delete(i);
        q_id.delete(i);
        q_val.delete(i);
        q_tag.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [1:0] rsn, input logic [4:0] rt,
                       input logic [1:0] rtn, input logic [4:0] dst, input logic we, input logic cls);
    rs_d = rs; rs_need = rsn; rt_d = rt; rt_need = rtn;
    dst_d = dst; we_d = we; cls_d = cls;
    flush_d = 1'b0; mdu_d = 1'b0; mdu_start = 1'b0; mdu_busy = 1'b0;
  endtask

  task automatic nop();
    drive(5'd0, NEED_NONE, 5'd0, NEED_NONE, 5'd0, 1'b0, CLS_ALU);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      nop();
    end
  endtask

  task automatic exp_at(input int dc, input int id, input logic [2:0] v, input string tag);
    q_cyc.push_back(cyc + dc);
    q_id.push_back(id);
    q_val.push_back(v);
    q_tag.push_back(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    nop();
    step();
    exp_at(0, I_STALL, 3'd0, "rst_stall");
    exp_at(0, I_RSD, SEL_RF, "rst_rs_d");
    exp_at(0, I_RTD, SEL_RF, "rst_rt_d");
    exp_at(0, I_RSE, SEL_RF, "rst_rs_e");
    exp_at(0, I_RTE, SEL_RF, "rst_rt_e");
    exp_at(0, I_RTM, SEL_RF, "rst_rt_m");
    step();
    reset = 1'b0;
    nop();

    // add $3 ; add $4,$3,$0 -> forward from M
    step(); drive(5'd1, NEED_E, 5'd2, NEED_E, 5'd3, 1'b1, CLS_ALU);
    exp_at(0, I_STALL, 3'd0, "a_first");
    step(); drive(5'd3, NEED_E, 5'd0, NEED_E, 5'd4, 1'b1, CLS_ALU);
    exp_at(0, I_STALL, 3'd0, "a_stall");
    exp_at(0, I_RSD, SEL_M, "a_rs_d");
    exp_at(0, I_RTD, SEL_RF, "a_rt_d");
    exp_at(1, I_RSE, SEL_M, "a_rs_e");
    exp_at(1, I_RTE, SEL_RF, "a_rt_e");
    idle(4);

    // lw $5 ; add $6,$5,$0 -> one stall, then forward from W
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd5, 1'b1, CLS_LOAD);
    step(); drive(5'd5, NEED_E, 5'd0, NEED_E, 5'd6, 1'b1, CLS_ALU);
    exp_at(0, I_STALL, 3'd1, "b_stall1");
    exp_at(1, I_RSE, SEL_RF, "b_bubble");
    step();
    exp_at(0, I_STALL, 3'd0, "b_go");
    exp_at(0, I_RSD, SEL_W, "b_rs_d");
    exp_at(1, I_RSE, SEL_W, "b_rs_e");
    idle(4);

    // add $8 ; sw $8 -> store data forwarded from W in M
    step(); drive(5'd0, NEED_NONE, 5'd0, NEED_NONE, 5'd8, 1'b1, CLS_ALU);
    step(); drive(5'd0, NEED_E, 5'd8, NEED_M, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_STALL, 3'd0, "s_stall");
    exp_at(0, I_RTD, SEL_W, "s_rt_d");
    exp_at(1, I_RTE, SEL_W, "s_rt_e");
    exp_at(2, I_RTM, SEL_W, "s_rt_m");
    idle(4);

    // lw $5 ; beq $5 -> two stalls
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd5, 1'b1, CLS_LOAD);
    step(); drive(5'd5, NEED_D, 5'd0, NEED_D, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_STALL, 3'd1, "c_ld_stall1");
    step();
    exp_at(0, I_STALL, 3'd1, "c_ld_stall2");
    step();
    exp_at(0, I_STALL, 3'd0, "c_ld_go");
    exp_at(0, I_RSD, SEL_W, "c_ld_rs_d");
    idle(4);

    // add $3 ; beq $3 -> one stall
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd3, 1'b1, CLS_ALU);
    step(); drive(5'd3, NEED_D, 5'd0, NEED_D, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_STALL, 3'd1, "c_alu_stall");
    step();
    exp_at(0, I_STALL, 3'd0, "c_alu_go");
    exp_at(0, I_RSD, SEL_M, "c_alu_rs_d");
    idle(4);

    // Register $0 is never tracked
    step(); drive(5'd1, NEED_E, 5'd2, NEED_E, 5'd0, 1'b1, CLS_ALU);
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd1, 1'b1, CLS_ALU);
    exp_at(0, I_STALL, 3'd0, "z_stall");
    exp_at(0, I_RSD, SEL_RF, "z_rs_d");
    exp_at(0, I_RTD, SEL_RF, "z_rt_d");
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd0, 1'b1, CLS_LOAD);
    step(); drive(5'd0, NEED_D, 5'd0, NEED_D, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_STALL, 3'd0, "z_ld_stall");
    exp_at(0, I_RSD, SEL_RF, "z_ld_rs_d");
    idle(4);

    // add $7 ; sub $7 ; consumer -> youngest producer wins
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd7, 1'b1, CLS_ALU);
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd7, 1'b1, CLS_ALU);
    step(); drive(5'd7, NEED_E, 5'd0, NEED_E, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_STALL, 3'd0, "y_stall");
    exp_at(0, I_RSD, SEL_M, "y_rs_d");
    exp_at(1, I_RSE, SEL_M, "y_rs_e");
    idle(4);

    // Producer in W: need-D forwards from W, need-E reads the register file; then retired
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd10, 1'b1, CLS_ALU);
    idle(2);
    step(); drive(5'd10, NEED_D, 5'd10, NEED_E, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_RSD, SEL_W, "r_rs_d");
    exp_at(0, I_RTD, SEL_RF, "r_rt_d");
    step();
    exp_at(0, I_RSD, SEL_RF, "r_gone");
    idle(4);

    // Flushed instruction neither issues nor carries its select into E
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd12, 1'b1, CLS_ALU);
    step(); drive(5'd12, NEED_E, 5'd0, NEED_E, 5'd11, 1'b1, CLS_LOAD);
    flush_d = 1'b1;
    exp_at(0, I_RSD, SEL_M, "f_rs_d");
    exp_at(1, I_RSE, SEL_RF, "f_bubble");
    step(); drive(5'd11, NEED_D, 5'd0, NEED_D, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_STALL, 3'd0, "f_no_issue");
    exp_at(0, I_RSD, SEL_RF, "f_rs_rf");
    idle(4);

    // MDU busy for five cycles
    for (int i = 0; i < 5; i++) begin
      step(); nop();
      mdu_d = 1'b1;
      mdu_busy = 1'b1;
      exp_at(0, I_STALL, MDU_EXP, "mdu_busy");
    end
    step(); nop();
    exp_at(0, I_STALL, 3'd0, "mdu_done");
    idle(2);

    // Reset in the middle of a load-use stall
    step(); drive(5'd0, NEED_E, 5'd0, NEED_E, 5'd5, 1'b1, CLS_LOAD);
    step(); drive(5'd5, NEED_D, 5'd0, NEED_D, 5'd0, 1'b0, CLS_ALU);
    exp_at(0, I_STALL, 3'd1, "x_stall");
    step();
    reset = 1'b1;
    exp_at(0, I_STALL, 3'd0, "x_rst_stall");
    exp_at(0, I_RSD, SEL_RF, "x_rst_rs_d");
    exp_at(0, I_RSE, SEL_RF, "x_rst_rs_e");
    exp_at(0, I_RTM, SEL_RF, "x_rst_rt_m");
    step();
    reset = 1'b0;
    exp_at(0, I_STALL, 3'd0, "x_post_stall");
    exp_at(0, I_RSD, SEL_RF, "x_post_rs_d");
    exp_at(1, I_RSE, SEL_RF, "x_post_rs_e");
    idle(3);

    if (q_cyc.size() != 0) begin
      n_fail += q_cyc.size();
      $display("FAIL unchecked expectations: got %0d pending, expected 0", q_cyc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
